id_exe_pipeline_reg: RTL

ID/EXE pipeline register for the 5-stage CPU. It consumes the hazard unit's `DEPEN[3:0]` forwarding flags and its active-low `LOAD_DEPEN` stall flag. On each edge it applies forwarding to the ID-stage operands, then registers the operands and control into the EXE stage. It also drives the PC / IF-ID write enables, inserts a bubble on a load-use stall or a flush, and keeps saturating stall/bubble performance counters.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/fwd_mux.sv | 23 ++
 rtl/id_exe_pipeline_reg.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EXE pipeline register: forwarding flag bit
// positions, ALU op width and the all-zero control word used for bubbles.
package pipe_pkg;

   localparam int DEP_EXE_A = 3;
   localparam int DEP_EXE_B = 2;
   localparam int DEP_MEM_A = 1;
   localparam int DEP_MEM_B = 0;

   localparam int ALUC_W = 4;

   typedef struct packed {
      logic              wreg;
      logic              sld;
      logic              wmem;
      logic              aluimm;
      logic [ALUC_W-1:0] aluc;
   } ctrl_t;

   localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/fwd_mux.sv
// Three-input priority select: the EXE-stage result beats the MEM-stage
// result, and the register-file value is used when neither is flagged.
module fwd_mux #(
   parameter int DATA_W = 32
) (
   input  logic              sel_exe,
   input  logic              sel_mem,
   input  logic [DATA_W-1:0] exe_val,
   input  logic [DATA_W-1:0] mem_val,
   input  logic [DATA_W-1:0] reg_val,
   output logic [DATA_W-1:0] out_val
);

   always_comb begin
      out_val = reg_val;
      if (sel_exe) begin
         out_val = exe_val;
      end else if (sel_mem) begin
         out_val = mem_val;
      end
   end

endmodule

// File: rtl/id_exe_pipeline_reg.sv
// ID/EXE pipeline register: forwards operands, registers them with decoded
// control into EXE, inserts bubbles on load-use stall or flush, counts stalls.
module id_exe_pipeline_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ID_ra,
   input  logic [DATA_W-1:0] ID_rb,
   input  logic [DATA_W-1:0] ID_imm,
   input  logic [4:0]        ID_rd,
   input  logic              ID_wreg,
   input  logic              ID_sld,
   input  logic              ID_wmem,
   input  logic              ID_aluimm,
   input  logic [ALUC_W-1:0] ID_aluc,
   input  logic [3:0]        DEPEN,
   input  logic              LOAD_DEPEN,
   input  logic              FLUSH,
   input  logic [DATA_W-1:0] EXE_fwd,
   input  logic [DATA_W-1:0] MEM_fwd,
   output logic              PC_WRITE,
   output logic              IFID_WRITE,
   output logic [DATA_W-1:0] EXE_a,
   output logic [DATA_W-1:0] EXE_b,
   output logic [DATA_W-1:0] EXE_imm,
   output logic [4:0]        EXE_rd,
   output logic              EXE_wreg,
   output logic              EXE_sld,
   output logic              EXE_wmem,
   output logic              EXE_aluimm,
   output logic [ALUC_W-1:0] EXE_aluc,
   output logic              EXE_valid,
   output logic [CNT_W-1:0]  STALL_CNT,
   output logic [CNT_W-1:0]  BUBBLE_CNT
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              stall;
   logic              bubble;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;

   logic [DATA_W-1:0] a_d, a_q;
   logic [DATA_W-1:0] b_d, b_q;
   logic [DATA_W-1:0] imm_d, imm_q;
   logic [4:0]        rd_d, rd_q;
   ctrl_t             ctrl_d, ctrl_q;
   logic              valid_d, valid_q;
   logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;

   assign stall      = ~LOAD_DEPEN;
   assign bubble     = stall | FLUSH;
   assign PC_WRITE   = LOAD_DEPEN;
   assign IFID_WRITE = LOAD_DEPEN;

   fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
      .sel_exe (DEPEN[DEP_EXE_A]),
      .sel_mem (DEPEN[DEP_MEM_A]),
      .exe_val (EXE_fwd),
      .mem_val (MEM_fwd),
      .reg_val (ID_ra),
      .out_val (fwd_a)
   );

   fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
      .sel_exe (DEPEN[DEP_EXE_B]),
      .sel_mem (DEPEN[DEP_MEM_B]),
      .exe_val (EXE_fwd),
      .mem_val (MEM_fwd),
      .reg_val (ID_rb),
      .out_val (fwd_b)
   );

   always_comb begin
      a_d     = '0;
      b_d     = '0;
      imm_d   = '0;
      rd_d    = '0;
      ctrl_d  = NOP_CTRL;
      valid_d = 1'b0;
      if (!bubble) begin
         a_d     = fwd_a;
         b_d     = fwd_b;
         imm_d   = ID_imm;
         rd_d    = ID_rd;
         ctrl_d  = '{wreg: ID_wreg, sld: ID_sld, wmem: ID_wmem,
                     aluimm: ID_aluimm, aluc: ID_aluc};
         valid_d = 1'b1;
      end
   end

   // Counters hold at all-ones instead of wrapping back to zero.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (stall && stall_cnt_q != CNT_MAX) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (bubble && bubble_cnt_q != CNT_MAX) begin
         bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q          <= '0;
         b_q          <= '0;
         imm_q        <= '0;
         rd_q         <= '0;
         ctrl_q       <= NOP_CTRL;
         valid_q      <= 1'b0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         a_q          <= a_d;
         b_q          <= b_d;
         imm_q        <= imm_d;
         rd_q         <= rd_d;
         ctrl_q       <= ctrl_d;
         valid_q      <= valid_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign EXE_a      = a_q;
   assign EXE_b      = b_q;
   assign EXE_imm    = imm_q;
   assign EXE_rd     = rd_q;
   assign EXE_wreg   = ctrl_q.wreg;
   assign EXE_sld    = ctrl_q.sld;
   assign EXE_wmem   = ctrl_q.wmem;
   assign EXE_aluimm = ctrl_q.aluimm;
   assign EXE_aluc   = ctrl_q.aluc;
   assign EXE_valid  = valid_q;
   assign STALL_CNT  = stall_cnt_q;
   assign BUBBLE_CNT = bubble_cnt_q;

endmodule
